// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_pkg
// Brief    : Shared types and carry-save helpers for wallace_mult_arbiter.
// Revision : 1.0
// ============================================================================
package mult_arb_pkg;

  localparam int OP_W     = 8;
  localparam int RES_W    = 16;
  // Tag storage sized for the largest supported requester count (8).
  localparam int ID_MAX_W = 3;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [RES_W-1:0] res_t;

  typedef struct packed {
    op_t                 x;
    op_t                 y;
    logic [ID_MAX_W-1:0] id;
  } s1_entry_t;

  function automatic res_t csa_sum(input res_t a, input res_t b, input res_t c);
    return a ^ b ^ c;
  endfunction

  function automatic res_t csa_carry(input res_t a, input res_t b, input res_t c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; the only state is the last-grant pointer.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int DW = IDX_W + 1;

  logic [IDX_W-1:0] last_q, last_d;
  logic [DW-1:0]    w_dist, w_best;
  logic             w_found;

  // Winner is the requester at the smallest circular distance after last_q.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_best    = '0;
    w_dist    = '0;
    for (int i = 0; i < N; i++) begin
      if (i > int'(last_q)) begin
        w_dist = DW'(i - int'(last_q) - 1);
      end else begin
        w_dist = DW'(i + N - int'(last_q) - 1);
      end
      if (req[i] && (!w_found || (w_dist < w_best))) begin
        w_found   = 1'b1;
        w_best    = w_dist;
        grant_idx = IDX_W'(i);
      end
    end
    if (w_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign last_d = advance ? grant_idx : last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IDX_W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wallace_mult.sv
`default_nettype none
// ============================================================================
// Module   : wallace_mult
// Brief    : Combinational unsigned 8x8 multiplier, carry-save Wallace tree.
// Revision : 1.0
// ============================================================================
module wallace_mult
  import mult_arb_pkg::*;
(
  input  op_t  a_i,
  input  op_t  b_i,
  output res_t p_o
);

  res_t w_pp [OP_W];

  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign w_pp[i] = b_i[i] ? (res_t'(a_i) << i) : '0;
  end

  res_t w_s0, w_c0, w_s1, w_c1, w_s2, w_c2;
  res_t w_s3, w_c3, w_s4, w_c4, w_s5, w_c5;

  // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
  assign w_s0 = csa_sum  (w_pp[0], w_pp[1], w_pp[2]);
  assign w_c0 = csa_carry(w_pp[0], w_pp[1], w_pp[2]);
  assign w_s1 = csa_sum  (w_pp[3], w_pp[4], w_pp[5]);
  assign w_c1 = csa_carry(w_pp[3], w_pp[4], w_pp[5]);

  assign w_s2 = csa_sum  (w_s0, w_c0, w_s1);
  assign w_c2 = csa_carry(w_s0, w_c0, w_s1);
  assign w_s3 = csa_sum  (w_c1, w_pp[6], w_pp[7]);
  assign w_c3 = csa_carry(w_c1, w_pp[6], w_pp[7]);

  assign w_s4 = csa_sum  (w_s2, w_c2, w_s3);
  assign w_c4 = csa_carry(w_s2, w_c2, w_s3);

  assign w_s5 = csa_sum  (w_s4, w_c4, w_c3);
  assign w_c5 = csa_carry(w_s4, w_c4, w_c3);

  assign p_o = w_s5 + w_c5;

endmodule
`default_nettype wire

// File: rtl/wallace_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wallace_mult_arbiter
// Brief    : Round-robin sharing of one Wallace multiplier, 2-stage pipeline.
// Revision : 1.0
// ============================================================================
module wallace_mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*OP_W-1:0] req_x,
  input  logic [NREQ*OP_W-1:0] req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output res_t                 rsp_data,
  input  logic                 rsp_ready,
  output logic                 busy
);

  logic [NREQ-1:0] w_grant;
  logic [ID_W-1:0] w_grant_idx;
  logic            w_out_adv, w_s1_adv, w_accept_en, w_accept;
  op_t             w_sel_x, w_sel_y;
  res_t            w_product;

  s1_entry_t       s1_q, s1_d;
  logic            s1_valid_q, s1_valid_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  res_t            rsp_data_q, rsp_data_d;

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (w_accept),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  wallace_mult u_mult (
    .a_i (s1_q.x),
    .b_i (s1_q.y),
    .p_o (w_product)
  );

  assign w_out_adv   = !rsp_valid_q | rsp_ready;
  assign w_s1_adv    = s1_valid_q & w_out_adv;
  // Reset masks acceptance so no transfer is signalled on the reset edge.
  assign w_accept_en = (!s1_valid_q | w_out_adv) & !reset;
  assign w_accept    = w_accept_en & (|req_valid);
  assign req_ready   = w_grant & {NREQ{w_accept_en}};

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_x = req_x[i*OP_W +: OP_W];
        w_sel_y = req_y[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;

    if (w_accept) begin
      s1_valid_d = 1'b1;
      s1_d.x     = w_sel_x;
      s1_d.y     = w_sel_y;
      s1_d.id    = ID_MAX_W'(w_grant_idx);
    end else if (w_s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (w_out_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_data_d = w_product;
        rsp_id_d   = ID_W'(s1_q.id);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = s1_valid_q | rsp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_wallace_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wallace_mult_arbiter
// Brief    : Directed and random bench with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_wallace_mult_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_x, req_y;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [15:0]       rsp_data;
  logic              rsp_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;

  wallace_mult_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue of accepted ops, capacity two; an op is
  // presented once it has seen two clock edges and is at the head.
  typedef struct {
    int x;
    int y;
    int id;
    int age;
  } ent_t;

  ent_t q[$];
  int   last_g = NREQ - 1;
  int   wait_cnt [NREQ];
  bit   live = 1'b0;

  always @(negedge clk) begin
    bit              vis, pop, acc_en, any;
    int              win;
    logic [NREQ-1:0] exp_ready;
    ent_t            e;

    vis    = (q.size() > 0) && (q[0].age >= 2);
    pop    = vis && rsp_ready;
    acc_en = !rst && ((q.size() < 2) || pop);
    any    = 1'b0;
    win    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last_g + k) % NREQ;
      if (!any && req_valid[c]) begin
        any = 1'b1;
        win = c;
      end
    end
    exp_ready = '0;
    if (any && acc_en) exp_ready[win] = 1'b1;

    if (live) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(vis));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      if (vis) begin
        chk("rsp_data", 32'(rsp_data), 32'(q[0].x * q[0].y));
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      end
    end

    if (rst) begin
      q.delete();
      last_g = NREQ - 1;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      live = 1'b1;
    end else if (live) begin
      if (pop) q.delete(0);
      foreach (q[i]) q[i].age++;
      if (any && acc_en) begin
        e.x   = int'(req_x[8*win +: 8]);
        e.y   = int'(req_y[8*win +: 8]);
        e.id  = win;
        e.age = 1;
        q.push_back(e);
        last_g = win;
        for (int i = 0; i < NREQ; i++) begin
          if (i == win) begin
            wait_cnt[i] = 0;
          end else if (req_valid[i]) begin
            wait_cnt[i]++;
            chk("starvation_bound", 32'(wait_cnt[i] < NREQ), 32'd1);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) wait_cnt[i] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int x, input int y);
    req_x[8*i +: 8] = 8'(x);
    req_y[8*i +: 8] = 8'(y);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst       = 1'b0;
  endtask

  int bx [4] = '{0, 1, 128, 255};
  int by [4] = '{200, 255, 2, 255};
  int bp [4] = '{0, 255, 256, 65025};

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("ready_during_reset", 32'(req_ready), 32'd0);
    tick();

    // Reset state, then a single op from requester 0
    rst       = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 12, 11);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("single_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_data", 32'(rsp_data), 32'd132);
    chk("single_id", 32'(rsp_id), 32'd0);
    tick();
    @(negedge clk);
    chk("single_busy_low", 32'(busy), 32'd0);

    // Round-robin fairness with all requesters active
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k <= 4) chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        chk("rr_rsp_data", 32'(rsp_data), 32'(10 * (k - 1)));
        chk("rr_rsp_id", 32'(rsp_id), 32'(k - 2));
      end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Back-pressure: two ops buffered, then stall; one-cycle release
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    set_op(2, 255, 255);
    @(negedge clk);
    chk("bp_accept0", 32'(req_ready), 32'b0100);
    tick();
    @(negedge clk);
    chk("bp_accept1", 32'(req_ready), 32'b0100);
    tick();
    @(negedge clk);
    chk("bp_full_ready", 32'(req_ready), 32'd0);
    chk("bp_data", 32'(rsp_data), 32'hFE01);
    tick();
    @(negedge clk);
    chk("bp_hold_data", 32'(rsp_data), 32'hFE01);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_refull_ready", 32'(req_ready), 32'd0);
    chk("bp_refull_valid", 32'(rsp_valid), 32'd1);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();

    // Boundary operands through requester 1
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        req_valid = 4'b0010;
        set_op(1, bx[k], by[k]);
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (k >= 2) begin
        chk("bound_valid", 32'(rsp_valid), 32'd1);
        chk("bound_data", 32'(rsp_data), 32'(bp[k-2]));
      end
      tick();
    end

    // Reset in the middle of a full pipeline
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_op(3, 7, 9);
    repeat (3) tick();
    @(negedge clk);
    chk("mid_full_busy", 32'(busy), 32'd1);
    chk("mid_full_ready", 32'(req_ready), 32'd0);
    rst       = 1'b1;
    req_valid = '1;
    set_op(0, 3, 5);
    @(negedge clk);
    chk("mid_reset_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_after_valid", 32'(rsp_valid), 32'd0);
    chk("mid_after_busy", 32'(busy), 32'd0);
    chk("mid_after_id", 32'(rsp_id), 32'd0);
    chk("mid_next_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_no_stale", 32'(rsp_valid), 32'd0);
    repeat (3) tick();

    // Random soak
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) set_op(i, 255, 255);
        else set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/wallace_mult_arbiter.md
Name: wallace_mult_arbiter

Overview:
- Shares one combinational 8x8 Wallace-tree multiplier (wallace_mult, instantiated internally) among NREQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Operand register, then multiplier, then result register: a 2-stage pipeline.
- One response channel carries the product tagged with the requester index.
- Sits between client blocks (e.g. a MAC/filter controller) and the multiplier datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, $clog2(NREQ), width of requester tag.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_x  in  NREQ*8  packed multiplicands; requester i uses bits [8i+7:8i].
- req_y  in  NREQ*8  packed multipliers; requester i uses bits [8i+7:8i].
- req_ready  out  NREQ  one-hot (or zero) acceptance; a transfer occurs when req_valid[i] & req_ready[i] at a clock edge.
- rsp_valid  out  1  result register holds a valid product.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  16  unsigned product x*y.
- rsp_ready  in  1  consumer accepts the response at a clock edge when rsp_valid is high.
- busy  out  1  high when either pipeline stage holds valid data.

Behaviour:
- Reset, applied at any clock edge including mid-operation:
  - Both stages become invalid; in-flight operations are discarded and not replayed.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req_ready=0 during the reset cycle.
  - RR pointer set so that requester 0 has highest priority.
- Stage advance rules:
  - out_adv = !rsp_valid | rsp_ready.
  - s1_adv = s1_valid & out_adv.
  - accept_en = !s1_valid | out_adv.
- Arbitration (combinational):
  - Search starts at index (last_grant+1) mod NREQ and wraps; the first requester with req_valid set wins.
  - req_ready[win] = accept_en; all other req_ready bits are 0.
  - req_ready never depends on req_x or req_y.
- Pointer update: last_grant <= win only on an accepting edge. Without a transfer the pointer holds.
- Stage 1, operand register:
  - On accept: latch x, y, id, and set s1_valid=1.
  - Else if s1_adv: s1_valid=0.
  - Else hold.
- Stage 2, result register:
  - When out_adv: rsp_valid <= s1_valid. If s1_valid, also rsp_data <= wallace_mult(s1_x, s1_y) and rsp_id <= s1_id.
  - rsp_data and rsp_id are stable while rsp_valid & !rsp_ready.
- Latency and throughput:
  - Request accepted at edge E0; rsp_valid rises after edge E0+1 (2-cycle latency).
  - Throughput is 1 op/cycle with no stalls.
- Back-pressure:
  - With rsp_ready held low, at most 2 ops are buffered (stage 1 + result).
  - Once both are full, all req_ready=0.
- Simultaneous events: in one cycle a response can be consumed, stage 1 can move to stage 2, and a new request can be accepted. No bubble is inserted.
- Width and arithmetic:
  - Unsigned 8x8 multiply, full 16-bit result, no truncation.
  - 255*255 = 65025 = 0xFE01.
- Ordering: responses leave in acceptance order. Per-requester order is preserved.
- Starvation freedom: a requester holding req_valid is granted within NREQ accepting edges.

Decomposition:
- Package mult_arb_pkg holds:
  - localparams OP_W=8 and RES_W=16.
  - Typedef op_t (logic [OP_W-1:0]) and res_t (logic [RES_W-1:0]).
  - Typedef s1_entry_t, a struct of {op_t x, op_t y, id}.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], advance, clk, reset.
  - Outputs: grant[N] (one-hot), grant_idx.
  - Contains only the pointer register.
- The top instantiates rr_arbiter, the stage registers and wallace_mult.

Test Plan:
- Reset then single op: req 0 sends x=12, y=11 → req_ready[0]=1 in that cycle; rsp_valid=1, rsp_id=0, rsp_data=132 two cycles later; busy falls after consumption.
- Round-robin fairness: all 4 requesters hold valid (x=i+1, y=10) with rsp_ready=1 → grants in order 0,1,2,3,0; responses 10,20,30,40 with ids 0,1,2,3; one response per cycle.
- Back-pressure: rsp_ready=0, req 2 streams x=255, y=255 → 2 accepts, then req_ready=0. rsp_data=0xFE01 held stable. Raising rsp_ready for 1 cycle releases one response and allows one new accept in the same cycle.
- Boundary operands: (0,200)→0, (1,255)→255, (128,2)→256, (255,255)→65025; each is checked against a golden model.
- Reset mid-operation: both stages full; assert reset for one edge → rsp_valid=0, busy=0, no stale response afterwards, next grant goes to requester 0.
- Random soak: 10k cycles of random valid/operands/rsp_ready → scoreboard matches every product and id in order; no requester waits longer than NREQ accepting edges.
